mcs4_ram_array: RTL



---
 rtl/mcs4_ram_array_if.sv | 28 ++
 rtl/mcs4_ram_array.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mcs4_ram_array_if.sv
// Bus bundle between the CPU/host side (master) and the 4002-class RAM array (slave).
// Carries the CM-RAM strobes, the shared 4-bit data bus, the output ports and the host access port.
interface mcs4_ram_array_if #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
);
  logic                    sync;
  logic [NUM_BANKS-1:0]    cm_ram;
  logic [3:0]              dbus_in;
  logic [3:0]              dbus_out;
  logic [NUM_BANKS*16-1:0] io_out;
  logic                    host_req;
  logic                    host_we;
  logic [BANK_W+8:0]       host_addr;
  logic [3:0]              host_wdata;
  logic                    host_ack;
  logic [3:0]              host_rdata;

  modport master (
    output sync, cm_ram, dbus_in, host_req, host_we, host_addr, host_wdata,
    input  dbus_out, io_out, host_ack, host_rdata
  );

  modport slave (
    input  sync, cm_ram, dbus_in, host_req, host_we, host_addr, host_wdata,
    output dbus_out, io_out, host_ack, host_rdata
  );
endinterface

// File: rtl/mcs4_ram_array.sv
// Multi-bank 4002-class RAM array (NUM_BANKS banks x 4 chips) on the i4004 bus.
// Define MCS4_RAM_HOST_EN to build the host (AXI-side) access port; otherwise host outputs are tied 0.
module mcs4_ram_array #(
  parameter int NUM_BANKS = 4,
  parameter int RESET_MEM = 1
) (
  input logic              clk,
  input logic              rst,
  mcs4_ram_array_if.slave  bus
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} instr_cyc_t;

  localparam logic [3:0] OP_WRM = 4'h0, OP_WMP = 4'h1, OP_WRR = 4'h2, OP_WPM = 4'h3;
  localparam logic [3:0] OP_WR0 = 4'h4, OP_WR1 = 4'h5, OP_WR2 = 4'h6, OP_WR3 = 4'h7;
  localparam logic [3:0] OP_SBM = 4'h8, OP_RDM = 4'h9, OP_RDR = 4'hA, OP_ADM = 4'hB;
  localparam logic [3:0] OP_RD0 = 4'hC, OP_RD1 = 4'hD, OP_RD2 = 4'hE, OP_RD3 = 4'hF;

  instr_cyc_t              phase_q, phase_d;
  logic [3:0]              opa_q;
  logic                    ioPending_q;
  logic                    srcPending_q;
  logic [BANK_W-1:0]       selBank_q;
  logic [1:0]              chip_q;
  logic [1:0]              regSel_q;
  logic [3:0]              charSel_q;
  logic [3:0]              rdata_q;
  logic [NUM_BANKS*16-1:0] ioOut_q;

  logic [3:0] mem_q    [NUM_BANKS*256];
  logic [3:0] status_q [NUM_BANKS*64];

  logic [BANK_W-1:0] lowBank_d;
  logic [BANK_W+3:0] cpuRegIdx;
  logic [BANK_W+7:0] cpuMemIdx;
  logic [3:0]        cpuRead_d;
  logic              ioExec;

  assign cpuRegIdx = {selBank_q, chip_q, regSel_q};
  assign cpuMemIdx = {cpuRegIdx, charSel_q};
  assign ioExec    = ioPending_q && !(opa_q == OP_WRR || opa_q == OP_WPM || opa_q == OP_RDR);

  always_comb begin
    phase_d = bus.sync ? A1 : instr_cyc_t'(phase_q + 3'd1);
  end

  // SRC selects the lowest-numbered bank whose CM-RAM line is active.
  always_comb begin
    lowBank_d = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (bus.cm_ram[b]) lowBank_d = BANK_W'(b);
    end
  end

  always_comb begin
    cpuRead_d = 4'h0;
    case (opa_q)
      OP_SBM, OP_RDM, OP_ADM:         cpuRead_d = mem_q[cpuMemIdx];
      OP_RD0, OP_RD1, OP_RD2, OP_RD3: cpuRead_d = status_q[{cpuRegIdx, opa_q[1:0]}];
      default:                        cpuRead_d = 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= A1;
      opa_q        <= 4'h0;
      ioPending_q  <= 1'b0;
      srcPending_q <= 1'b0;
      selBank_q    <= '0;
      chip_q       <= 2'd0;
      regSel_q     <= 2'd0;
      charSel_q    <= 4'h0;
      rdata_q      <= 4'h0;
    end else begin
      phase_q <= phase_d;
      case (phase_q)
        M2: begin
          opa_q       <= bus.dbus_in;
          ioPending_q <= bus.cm_ram[selBank_q];
        end
        X1: rdata_q <= ioExec ? cpuRead_d : 4'h0;
        X2: begin
          if (|bus.cm_ram) begin
            srcPending_q        <= 1'b1;
            selBank_q           <= lowBank_d;
            {chip_q, regSel_q}  <= bus.dbus_in;
          end else begin
            srcPending_q <= 1'b0;
          end
        end
        X3: if (srcPending_q) charSel_q <= bus.dbus_in;
        default: ;
      endcase
    end
  end

  assign bus.dbus_out = (phase_q == X2) ? rdata_q : 4'h0;
  assign bus.io_out   = ioOut_q;

`ifdef MCS4_RAM_HOST_EN
  logic [BANK_W-1:0] hBank;
  logic [1:0]        hChip;
  logic [1:0]        hReg;
  logic              hIsStatus;
  logic [3:0]        hIdx;
  logic              hostValid;
  logic              hostAccept;
  logic [3:0]        hostRead_d;
  logic              hostAck_q;
  logic [3:0]        hostRdata_q;

  assign {hBank, hChip, hReg, hIsStatus, hIdx} = bus.host_addr;
  assign hostValid  = (int'(hBank) < NUM_BANKS) && !(hIsStatus && hIdx[3:2] != 2'b00);
  // X2 belongs to the CPU, so host and CPU writes never land on the same edge.
  assign hostAccept = bus.host_req && !hostAck_q && (phase_q != X2);

  always_comb begin
    hostRead_d = 4'h0;
    if (hostValid) begin
      hostRead_d = hIsStatus ? status_q[{hBank, hChip, hReg, hIdx[1:0]}]
                             : mem_q[{hBank, hChip, hReg, hIdx}];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hostAck_q   <= 1'b0;
      hostRdata_q <= 4'h0;
    end else begin
      hostAck_q <= hostAccept;
      if (hostAccept) hostRdata_q <= hostRead_d;
    end
  end

  assign bus.host_ack   = hostAck_q;
  assign bus.host_rdata = hostRdata_q;
`else
  logic unusedHost;
  assign unusedHost     = ^{bus.host_req, bus.host_we, bus.host_addr, bus.host_wdata};
  assign bus.host_ack   = 1'b0;
  assign bus.host_rdata = 4'h0;
`endif

  // CPU writes commit on the edge ending X2; host writes commit on accept (never in X2).
  always_ff @(posedge clk) begin
    if (rst) begin
      ioOut_q <= '0;
      if (RESET_MEM != 0) begin
        for (int i = 0; i < NUM_BANKS * 256; i++) mem_q[i] <= 4'h0;
        for (int i = 0; i < NUM_BANKS * 64; i++) status_q[i] <= 4'h0;
      end
    end else begin
      if (phase_q == X2 && ioExec) begin
        case (opa_q)
          OP_WRM: mem_q[cpuMemIdx] <= bus.dbus_in;
          OP_WMP: ioOut_q[{selBank_q, chip_q, 2'b00} +: 4] <= bus.dbus_in;
          OP_WR0, OP_WR1, OP_WR2, OP_WR3: status_q[{cpuRegIdx, opa_q[1:0]}] <= bus.dbus_in;
          default: ;
        endcase
      end
`ifdef MCS4_RAM_HOST_EN
      if (hostAccept && bus.host_we && hostValid) begin
        if (hIsStatus) status_q[{hBank, hChip, hReg, hIdx[1:0]}] <= bus.host_wdata;
        else           mem_q[{hBank, hChip, hReg, hIdx}]         <= bus.host_wdata;
      end
`endif
    end
  end
endmodule
